// File: rtl/ntt_cmd_sequencer_pkg.sv
// ntt_cmd_sequencer_pkg: shared command layout, mode encodings and FSM states
package ntt_cmd_sequencer_pkg;
   localparam int MODE_W = 2;
   localparam int OFF_W  = 10;
   localparam int CMD_W  = MODE_W + 1 + 3 * OFF_W;
   typedef enum logic [MODE_W-1:0] {
      MODE_NTT    = 2'd0,
      MODE_INVNTT = 2'd1,
      MODE_MULT   = 2'd2,
      MODE_ADDSUB = 2'd3
   } mode_e;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_CLEAR = 3'd3,
      S_GAP   = 3'd4
   } state_e;
   typedef struct packed {
      logic [MODE_W-1:0] mode;
      logic              sub;
      logic [OFF_W-1:0]  off_a;
      logic [OFF_W-1:0]  off_b;
      logic [OFF_W-1:0]  off_w;
   } cmd_t;
endpackage

// File: rtl/ntt_cmd_fifo.sv
// ntt_cmd_fifo: DEPTH-entry command queue with count-based full/empty
module ntt_cmd_fifo
   import ntt_cmd_sequencer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [CMD_W-1:0] wdata,
   output logic [CMD_W-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [CMD_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             wr_en, rd_en;
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign rdata = mem[rd_ptr];
   // storage needs no reset: empty masks whatever stale entries remain
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= wdata;
   // pointers wrap naturally; count tracks occupancy for full/empty
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      end
endmodule

// File: rtl/ntt_cmd_sequencer.sv
// ntt_cmd_sequencer: queues host commands and issues them to the NTT processor one at a time
module ntt_cmd_sequencer
   import ntt_cmd_sequencer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 511
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic             cmd_sub,
   input  logic [9:0]       cmd_off_a,
   input  logic [9:0]       cmd_off_b,
   input  logic [9:0]       cmd_off_w,
   output logic             ntt_start,
   output logic [1:0]       ntt_mode,
   output logic             ntt_sub,
   output logic [9:0]       ntt_off_a,
   output logic [9:0]       ntt_off_b,
   output logic [9:0]       ntt_off_w,
   input  logic             ntt_finish,
   output logic             proc_clr,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic             err_clr
);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   state_e          state, state_nxt;
   cmd_t            cmd_in, head, cur;
   logic            full, empty, pop, timeout;
   logic [WD_W-1:0] wd;
   assign cmd_in = {cmd_mode, cmd_sub, cmd_off_a, cmd_off_b, cmd_off_w};
   ntt_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .pop   (pop),
      .wdata (cmd_in),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );
   assign timeout   = state == S_WAIT && !ntt_finish && wd == WD_W'(TIMEOUT);
   assign cmd_ready = !full;
   assign ntt_start = state == S_ISSUE;
   assign proc_clr  = state == S_CLEAR;
   assign done      = state == S_WAIT && ntt_finish;
   assign busy      = !empty || state != S_IDLE;
   assign ntt_mode  = cur.mode;
   assign ntt_sub   = cur.sub;
   assign ntt_off_a = cur.off_a;
   assign ntt_off_b = cur.off_b;
   assign ntt_off_w = cur.off_w;
   // next state: finish beats a coincident timeout because timeout is masked by ntt_finish
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         S_IDLE:  state_nxt = empty ? S_IDLE : S_ISSUE;
         S_ISSUE: begin
            pop       = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT:  state_nxt = (ntt_finish || timeout) ? S_CLEAR : S_WAIT;
         S_CLEAR: state_nxt = S_GAP;
         default: state_nxt = S_IDLE;
      endcase
   end
   // state, captured command, watchdog and sticky error
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= S_IDLE;
         cur   <= '0;
         wd    <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && !empty) cur <= head;
         wd  <= state == S_ISSUE ? WD_W'(1) :
                (state == S_WAIT && !ntt_finish && !timeout) ? wd + 1'b1 : '0;
         err <= err_clr ? 1'b0 : (timeout ? 1'b1 : err);
      end
endmodule

// File: tb/tb_ntt_cmd_sequencer.sv
// tb_ntt_cmd_sequencer: directed and randomized checks against a transaction-level queue model
module tb_ntt_cmd_sequencer;
   import ntt_cmd_sequencer_pkg::*;
   localparam int TIMEOUT = 511;
   logic       clk = 0, rst = 1;
   logic       cmd_valid = 0, cmd_sub = 0, ntt_finish = 0, err_clr = 0;
   logic [1:0] cmd_mode = 0;
   logic [9:0] cmd_off_a = 0, cmd_off_b = 0, cmd_off_w = 0;
   logic       cmd_ready, ntt_start, ntt_sub, proc_clr, busy, done, err;
   logic [1:0] ntt_mode;
   logic [9:0] ntt_off_a, ntt_off_b, ntt_off_w;
   int   checks = 0, errors = 0, cyc = 0, start_cyc = 0, done_seen = 0, issued = 0;
   logic err_exp = 0;
   cmd_t exp_q[$];
   cmd_t last_cmd, c5, cx;

   ntt_cmd_sequencer #(.DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_sub(cmd_sub), .cmd_off_a(cmd_off_a),
      .cmd_off_b(cmd_off_b), .cmd_off_w(cmd_off_w), .ntt_start(ntt_start),
      .ntt_mode(ntt_mode), .ntt_sub(ntt_sub), .ntt_off_a(ntt_off_a),
      .ntt_off_b(ntt_off_b), .ntt_off_w(ntt_off_w), .ntt_finish(ntt_finish),
      .proc_clr(proc_clr), .busy(busy), .done(done), .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic cmd_t mk(input int m, input int s, input int a, input int b, input int w);
      cmd_t c;
      c.mode = 2'(m); c.sub = 1'(s); c.off_a = 10'(a); c.off_b = 10'(b); c.off_w = 10'(w);
      return c;
   endfunction

   function automatic cmd_t rnd_cmd();
      return mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023));
   endfunction

   task automatic drive(input cmd_t c);
      {cmd_mode, cmd_sub, cmd_off_a, cmd_off_b, cmd_off_w} = c;
   endtask

   task automatic push(input cmd_t c);
      drive(c);
      cmd_valid = 1;
      #1;
      chk("push_ready", cmd_ready, 1);
      exp_q.push_back(c);
      tick();
      cmd_valid = 0;
   endtask

   task automatic chk_fields(input cmd_t e);
      chk("fields", {ntt_mode, ntt_sub, ntt_off_a, ntt_off_b, ntt_off_w}, e);
   endtask

   // wait for the next start; exp_n < 0 skips the spacing check
   task automatic get_start(input int exp_n);
      int n = 0;
      #1;
      while (ntt_start !== 1'b1 && n < 40) begin
         tick();
         #1;
         n++;
      end
      chk("start_seen", ntt_start, 1);
      if (exp_n >= 0) chk("start_spacing", n, exp_n);
      last_cmd = exp_q.pop_front();
      chk_fields(last_cmd);
      issued++;
      start_cyc = cyc;
   endtask

   // complete the command in flight: finish L cycles after start, or let the watchdog fire
   task automatic finish_cmd(input int lat, input bit to);
      if (to) begin
         while (cyc < start_cyc + TIMEOUT) begin
            tick(); #1;
            chk("wait_done", done, 0);
            chk("wait_clr", proc_clr, 0);
         end
         chk("err_before_timeout", err, err_exp);
         tick(); #1;
         chk("timeout_clr", proc_clr, 1);
         chk("timeout_err", err, 1);
         chk("timeout_no_done", done, 0);
         err_exp = 1;
      end else begin
         while (cyc < start_cyc + lat - 1) begin
            tick(); #1;
            chk("wait_done", done, 0);
            chk("wait_clr", proc_clr, 0);
            chk("wait_fields", {ntt_mode, ntt_sub, ntt_off_a, ntt_off_b, ntt_off_w}, last_cmd);
         end
         tick();
         ntt_finish = 1;
         #1;
         chk("finish_done", done, 1);
         chk("finish_no_clr", proc_clr, 0);
         if (done === 1'b1) done_seen++;
         tick();
         ntt_finish = 0;
         #1;
         chk("clr_pulse", proc_clr, 1);
         chk("clr_no_done", done, 0);
         chk("clr_err", err, err_exp);
      end
      tick(); #1;
      chk("gap_clr", proc_clr, 0);
      chk("gap_start", ntt_start, 0);
   endtask

   initial begin
      #1;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_outs", {ntt_start, proc_clr, busy, done, err}, 0);
      chk("rst_fields", {ntt_mode, ntt_sub, ntt_off_a, ntt_off_b, ntt_off_w}, 0);
      tick(); tick();
      rst = 0;
      tick();

      // single NTT command with a 229-cycle run
      push(mk(MODE_NTT, 0, 0, 0, 64));
      get_start(1);
      finish_cmd(229, 0);
      chk("busy_gap", busy, 1);
      tick(); #1;
      chk("busy_idle", busy, 0);
      chk("held_fields", {ntt_mode, ntt_sub, ntt_off_a, ntt_off_b, ntt_off_w}, last_cmd);

      // fill the FIFO behind a command in flight
      push(mk(MODE_MULT, 0, $urandom_range(0, 1023), $urandom_range(0, 1023), 5));
      get_start(1);
      tick();
      push(mk(MODE_ADDSUB, 1, 11, 22, 33));
      push(mk(MODE_NTT, 0, 44, 55, 66));
      push(mk(MODE_INVNTT, 0, 77, 88, 99));
      push(rnd_cmd());
      cx = rnd_cmd();
      drive(cx);
      cmd_valid = 1;
      #1;
      chk("full_ready", cmd_ready, 0);
      tick(); #1;
      chk("full_ready_hold", cmd_ready, 0);
      cmd_valid = 0;
      finish_cmd(40, 0);

      // push attempt while full and a pop happens in the same cycle
      tick(); tick();
      c5 = rnd_cmd();
      drive(c5);
      cmd_valid = 1;
      #1;
      chk("issue_start", ntt_start, 1);
      last_cmd = exp_q.pop_front();
      chk_fields(last_cmd);
      issued++;
      chk("pop_full_ready", cmd_ready, 0);
      start_cyc = cyc;
      tick(); #1;
      chk("after_pop_ready", cmd_ready, 1);
      exp_q.push_back(c5);
      tick();
      cmd_valid = 0;
      finish_cmd($urandom_range(3, 120), 0);
      for (int i = 0; i < 4; i++) begin
         get_start(2);
         finish_cmd($urandom_range(1, 260), 0);
      end
      chk("queue_drained", exp_q.size(), 0);
      chk("done_count", done_seen, issued);
      tick(); #1;
      chk("drained_busy", busy, 0);

      // watchdog abort, queued command still issues, then err_clr
      push(rnd_cmd());
      get_start(1);
      push(rnd_cmd());
      finish_cmd(0, 1);
      get_start(2);
      tick();
      err_clr = 1;
      #1;
      chk("err_sticky", err, 1);
      tick();
      err_clr = 0;
      #1;
      chk("err_cleared", err, 0);
      err_exp = 0;
      finish_cmd(30, 0);

      // asynchronous reset while waiting with two commands queued
      tick();
      push(rnd_cmd());
      get_start(1);
      push(rnd_cmd());
      push(rnd_cmd());
      tick();
      rst = 1;
      #1;
      chk("arst_outs", {ntt_start, proc_clr, busy, done, err}, 0);
      chk("arst_ready", cmd_ready, 1);
      chk("arst_fields", {ntt_mode, ntt_sub, ntt_off_a, ntt_off_b, ntt_off_w}, 0);
      exp_q.delete();
      tick();
      rst = 0;
      for (int i = 0; i < 10; i++) begin
         tick(); #1;
         chk("post_rst_quiet", {ntt_start, busy, proc_clr}, 0);
      end
      push(rnd_cmd());
      get_start(1);
      finish_cmd($urandom_range(5, 100), 0);
      tick();

      // finish glitch while idle is ignored
      ntt_finish = 1;
      #1;
      chk("glitch_done", done, 0);
      tick(); #1;
      chk("glitch_clr", proc_clr, 0);
      chk("glitch_busy", busy, 0);
      ntt_finish = 0;

      // randomized commands and latencies
      for (int i = 0; i < 6; i++) begin
         tick();
         push(rnd_cmd());
         get_start(1);
         finish_cmd($urandom_range(1, 300), 0);
      end
      tick(); #1;
      chk("final_idle", {busy, err}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
